// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter sequencer.
// Holds the FSM state encoding and the reset/trap vector defaults.
package pc_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;

    localparam int          DEF_INC          = 4;
    localparam int unsigned DEF_ALIGN_BITS   = 2;
    localparam addr_t       DEF_RESET_VECTOR = '0;
    localparam addr_t       DEF_TRAP_VECTOR  = addr_t'('h10);

    typedef enum logic [1:0] {
        PCS_BOOT,
        PCS_RUN,
        PCS_HOLD
    } pcs_state_t;

    // A zero alignment width yields an empty mask, which disables the check.
    function automatic addr_t alignMask(int unsigned bits);
        addr_t mask;
        if (bits == 0) begin
            mask = '0;
        end else begin
            mask = (addr_t'(1) << bits) - addr_t'(1);
        end
        return mask;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between control logic and the PC sequencer.
// The master side issues stall and redirect requests; the slave side returns the fetch PC.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);

    logic            stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_inc;
    logic            pc_valid;
    logic            misaligned;

    modport master (
        output stall,
        output branch_taken,
        output branch_target,
        output jump,
        output jump_target,
        input  pc,
        input  pc_plus_inc,
        input  pc_valid,
        input  misaligned
    );

    modport slave (
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  jump,
        input  jump_target,
        output pc,
        output pc_plus_inc,
        output pc_valid,
        output misaligned
    );

endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry buffer that parks a redirect target while the pipeline is stalled.
// A load overwrites any held entry, so the newest redirect always wins.
module pc_redirect_buf #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] target_o,
    output logic            valid_o
);

    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] target_d;
    logic            valid_q;
    logic            valid_d;

    // Load takes precedence over clear so a same-cycle refill is never lost.
    always_comb begin
        target_d = target_q;
        valid_d  = valid_q;
        if (load_i) begin
            target_d = target_i;
            valid_d  = 1'b1;
        end else if (clear_i) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            target_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            target_q <= target_d;
            valid_q  <= valid_d;
        end
    end

    assign target_o = target_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch program counter with stall hold, a pending-redirect buffer
// and a trap on misaligned redirect targets.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = pc_pkg::XLEN,
    parameter int              INC          = DEF_INC,
    parameter int unsigned     ALIGN_BITS   = DEF_ALIGN_BITS,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR)
) (
    input  logic         clock,
    input  logic         reset,
    pc_sequencer_if.slave bus
);

    localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(alignMask(ALIGN_BITS));

    pcs_state_t      state_q;
    pcs_state_t      state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            pcValid_q;
    logic            pcValid_d;
    logic            misaligned_q;
    logic            misaligned_d;

    logic            redirReq;
    logic [XLEN-1:0] redirTarget;
    logic [XLEN-1:0] pcPlusInc;
    logic            doApply;
    logic            doAdvance;
    logic [XLEN-1:0] applyTarget;

    logic            bufLoad;
    logic            bufClear;
    logic [XLEN-1:0] bufTarget;
    logic            bufValid;

    assign redirReq    = bus.jump | bus.branch_taken;
    assign redirTarget = bus.jump ? bus.jump_target : bus.branch_target;
    assign pcPlusInc   = pc_q + INC_W;

    pc_redirect_buf #(
        .XLEN(XLEN)
    ) u_redirect_buf (
        .clock    (clock),
        .reset    (reset),
        .load_i   (bufLoad),
        .clear_i  (bufClear),
        .target_i (redirTarget),
        .target_o (bufTarget),
        .valid_o  (bufValid)
    );

    // Decide what happens this cycle; a fresh redirect on stall release beats the parked one.
    always_comb begin
        state_d     = state_q;
        pcValid_d   = pcValid_q;
        bufLoad     = 1'b0;
        bufClear    = 1'b0;
        doApply     = 1'b0;
        doAdvance   = 1'b0;
        applyTarget = redirTarget;
        case (state_q)
            PCS_BOOT: begin
                state_d   = PCS_RUN;
                pcValid_d = 1'b1;
            end
            PCS_RUN: begin
                if (!bus.stall) begin
                    if (redirReq) begin
                        doApply = 1'b1;
                    end else begin
                        doAdvance = 1'b1;
                    end
                end else if (redirReq) begin
                    bufLoad = 1'b1;
                    state_d = PCS_HOLD;
                end
            end
            PCS_HOLD: begin
                if (bus.stall) begin
                    bufLoad = redirReq;
                end else begin
                    bufClear = 1'b1;
                    state_d  = PCS_RUN;
                    if (redirReq) begin
                        doApply = 1'b1;
                    end else if (bufValid) begin
                        doApply     = 1'b1;
                        applyTarget = bufTarget;
                    end else begin
                        doAdvance = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = PCS_BOOT;
                pcValid_d = 1'b0;
            end
        endcase
    end

    // Any redirect landing off the alignment grid is replaced by the trap vector.
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        if (doApply) begin
            if ((applyTarget & ALIGN_MASK) != '0) begin
                pc_d         = TRAP_VECTOR;
                misaligned_d = 1'b1;
            end else begin
                pc_d = applyTarget;
            end
        end else if (doAdvance) begin
            pc_d = pcPlusInc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= PCS_BOOT;
            pc_q         <= RESET_VECTOR;
            pcValid_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pcValid_q    <= pcValid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus_inc = pcPlusInc;
    assign bus.pc_valid    = pcValid_q;
    assign bus.misaligned  = misaligned_q;

endmodule
